tlul_rsp_intg_chk_slice: RTL and testbench
==========================================

Name: tlul_rsp_intg_chk_slice

Overview:
- Host-side TL-UL D-channel register slice that consumes responses carrying integrity produced by the device-side response integrity generator.
- Buffers each response in a 2-entry full-throughput skid buffer.
- Checks response integrity (SECDED inverted 64/57 over opcode/size/error) and data integrity (inverted 39/32 over data) on every accepted beat.
- Raises a sticky error and an alert request/acknowledge handshake.

Parameters:
- EnableRspIntgChk, 1'b1, enable response-integrity check; 0 ties the rsp check result to "no error".
- EnableDataIntgChk, 1'b1, enable data-integrity check; 0 ties the data check result to "no error".

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- tl_d_i  in  66  packed d2h response from the device side. Bit layout:
  - d_valid [65], d_opcode [64:62], d_param [61:59], d_size [58:57], d_source [56:49], d_sink [48], d_data [47:16]
  - d_user: rsp_intg [15:9], data_intg [8:2]
  - d_error [1], a_ready [0]
- d_ready_o  out  1  upstream D-channel ready.
- tl_d_o  out  66  registered d2h response to the host, same layout.
- d_ready_i  in  1  host D-channel ready.
- intg_err_o  out  1  sticky integrity error flag.
- alert_req_o  out  1  alert request.
- alert_ack_i  in  1  alert acknowledge.

Behaviour:
- Reset values: tl_d_o all zero (d_valid=0), d_ready_o=1, intg_err_o=0, alert_req_o=0, buffer empty. Reset mid-transfer discards buffered beats without further handshakes.
- a_ready (bit 0) passes combinationally from tl_d_i to tl_d_o and bypasses the buffer.
- Beat transfer: upstream transfers when tl_d_i[65] & d_ready_o; downstream transfers when tl_d_o[65] & d_ready_i.
- Skid buffer: one main register plus one skid register.
  - d_ready_o = !skid_full, registered with no combinational path from d_ready_i.
  - Latency is 1 cycle input-to-output. Sustained throughput is 1 beat/cycle when d_ready_i=1.
  - EMPTY: an accept loads main → ONE.
  - ONE, accept with no drain → skid loads → FULL, d_ready_o=0 next cycle.
  - ONE, simultaneous accept and drain → main reloads, stays ONE.
  - ONE, drain only → EMPTY.
  - FULL, drain → skid moves to main → ONE.
  - FULL never accepts. Ordering is strictly FIFO.
- Check:
  - The response payload is the 57-bit zero-extension of {opcode, size, d_error}.
  - Syndromes are computed combinationally on tl_d_i for each accepted beat.
  - Any nonzero syndrome, correctable or not, is an error.
  - Data is checked for every opcode.
- Error flag:
  - err_pulse asserted on an accepted beat sets intg_err_o and alert_req_o in the next cycle.
  - alert_req_o holds until alert_ack_i=1 is sampled, then clears the cycle after.
  - If ack and a new err_pulse coincide, alert_req_o stays 1.
  - intg_err_o never clears except on reset.
- The beat itself is forwarded unchanged unless the optional feature is enabled.

Optional Feature:
- Macro: TLUL_RSP_CHK_BLOCK_EN.
- Defined: a beat whose check fails is stored with d_error forced to 1 and d_data forced to 32'h0. rsp_intg and data_intg are re-encoded (encoders instantiated) so that downstream checks pass on the corrupted-to-error beat. All subsequent beats after intg_err_o=1 are also forced this way.
- Undefined: beats pass bit-exact and no encoders are instantiated.

Decomposition:
- Shared package tlul_pkg (existing) holds:
  - bit-offset localparams for the 66-bit d2h layout
  - D2HRspIntgWidth=7, DataIntgWidth=7, D2HRspMaxWidth=57
  - opcode constants AccessAck=0, AccessAckData=1
- One sub-module: tlul_rsp_intg_chk_core, combinational. It wraps prim_secded_inv_64_57_dec and prim_secded_inv_39_32_dec and outputs err_pulse_raw.
- The slice FSM, buffer and alert logic stay in the top.

Test Plan:
- Clean stream: 8 AccessAckData beats, data 32'h0000_0001..8 with valid encodings, d_ready_i=1 → identical beats on tl_d_o one cycle later, intg_err_o=0, d_ready_o=1 throughout.
- Backpressure: d_ready_i=0 for 3 cycles while 3 beats are offered → d_ready_o falls after 2 accepts. The third beat is held upstream. Releasing d_ready_i drains beats in order with no loss or duplication.
- Data flip: a valid beat with data 32'hDEAD_BEEF and bit 16 (data bit 0) flipped → intg_err_o=1 and alert_req_o=1 the cycle after the accept. The beat is forwarded unchanged, or with d_error=1 and data 0 under TLUL_RSP_CHK_BLOCK_EN.
- Rsp flip: a beat with rsp_intg bit 9 flipped → error raised. Applying alert_ack_i=1 for one cycle → alert_req_o clears next cycle while intg_err_o stays 1.
- Coincident ack and new error → alert_req_o stays 1. Assert rst_i asynchronously with FULL buffer → all outputs return to reset values immediately, and the buffer is empty after release.
- Parameters EnableRspIntgChk=0 and EnableDataIntgChk=0 with corrupted beats → no error raised.

Source files
------------

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: the 66-bit d2h bit layout, integrity widths,
// D-channel opcodes and the slice state type.
package tlul_pkg;

  // Packed d2h response layout (bit positions within the 66-bit vector)
  localparam int D2HWidth     = 66;
  localparam int DValidBit    = 65;
  localparam int DOpcodeMsb   = 64;
  localparam int DOpcodeLsb   = 62;
  localparam int DParamMsb    = 61;
  localparam int DParamLsb    = 59;
  localparam int DSizeMsb     = 58;
  localparam int DSizeLsb     = 57;
  localparam int DSourceMsb   = 56;
  localparam int DSourceLsb   = 49;
  localparam int DSinkBit     = 48;
  localparam int DDataMsb     = 47;
  localparam int DDataLsb     = 16;
  localparam int DRspIntgMsb  = 15;
  localparam int DRspIntgLsb  = 9;
  localparam int DDataIntgMsb = 8;
  localparam int DDataIntgLsb = 2;
  localparam int DErrorBit    = 1;
  localparam int AReadyBit    = 0;

  localparam int D2HRspIntgWidth = 7;
  localparam int DataIntgWidth   = 7;
  localparam int D2HRspMaxWidth  = 57;

  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  // Occupancy of the two-entry response slice
  typedef enum logic [1:0] {
    SliceEmpty = 2'd0,
    SliceOne   = 2'd1,
    SliceFull  = 2'd2
  } slice_state_e;

  // Response-integrity payload: {opcode, size, error} zero-extended to 57 bits
  function automatic logic [D2HRspMaxWidth-1:0] rsp_payload(
    input logic [2:0] opcode,
    input logic [1:0] size,
    input logic       error
  );
    return {51'b0, opcode, size, error};
  endfunction

endpackage

// File: rtl/prim_secded_inv.sv
// Inverted SECDED primitives: 64/57 for response integrity and 39/32 for
// data integrity. Check bits are stored XOR-ed with a fixed pattern so an
// all-zero word is never a valid codeword. Decoders report a nonzero
// syndrome as err_o[0] (odd weight, single-bit) or err_o[1] (even weight).
// The encoders exist only when TLUL_RSP_CHK_BLOCK_EN is defined.

module prim_secded_inv_64_57_dec (
  input  logic [63:0] data_i,
  output logic [1:0]  err_o
);
  logic [56:0] d;
  logic [6:0]  c;
  logic [6:0]  syndrome;

  assign d = data_i[56:0];
  assign c = data_i[63:57] ^ 7'h2A;

  // Recompute each parity group and compare with the received check bit
  always_comb begin
    syndrome[0] = ^(d & 57'h103FFF800007FFF) ^ c[0];
    syndrome[1] = ^(d & 57'h17C1FF801FF801F) ^ c[1];
    syndrome[2] = ^(d & 57'h1BDE1F87E0781E1) ^ c[2];
    syndrome[3] = ^(d & 57'h1DEEE3B8E388E22) ^ c[3];
    syndrome[4] = ^(d & 57'h1EF76CDB2C93244) ^ c[4];
    syndrome[5] = ^(d & 57'h1F7BB56D5525488) ^ c[5];
    syndrome[6] = ^(d & 57'h1FBDDA769A46910) ^ c[6];
  end

  assign err_o[0] = ^syndrome;
  assign err_o[1] = ~(^syndrome) & (|syndrome);
endmodule

module prim_secded_inv_39_32_dec (
  input  logic [38:0] data_i,
  output logic [1:0]  err_o
);
  logic [31:0] d;
  logic [6:0]  c;
  logic [6:0]  syndrome;

  assign d = data_i[31:0];
  assign c = data_i[38:32] ^ 7'h2A;

  // Recompute each parity group and compare with the received check bit
  always_comb begin
    syndrome[0] = ^(d & 32'h2606BD25) ^ c[0];
    syndrome[1] = ^(d & 32'hDEBA8050) ^ c[1];
    syndrome[2] = ^(d & 32'h413D89AA) ^ c[2];
    syndrome[3] = ^(d & 32'h31234ED1) ^ c[3];
    syndrome[4] = ^(d & 32'hC2C1323B) ^ c[4];
    syndrome[5] = ^(d & 32'h2DCC624C) ^ c[5];
    syndrome[6] = ^(d & 32'h98505586) ^ c[6];
  end

  assign err_o[0] = ^syndrome;
  assign err_o[1] = ~(^syndrome) & (|syndrome);
endmodule

`ifdef TLUL_RSP_CHK_BLOCK_EN
module prim_secded_inv_64_57_enc (
  input  logic [56:0] data_i,
  output logic [63:0] data_o
);
  logic [6:0] c;

  // Parity groups, then inversion of the check field
  always_comb begin
    c[0] = ^(data_i & 57'h103FFF800007FFF);
    c[1] = ^(data_i & 57'h17C1FF801FF801F);
    c[2] = ^(data_i & 57'h1BDE1F87E0781E1);
    c[3] = ^(data_i & 57'h1DEEE3B8E388E22);
    c[4] = ^(data_i & 57'h1EF76CDB2C93244);
    c[5] = ^(data_i & 57'h1F7BB56D5525488);
    c[6] = ^(data_i & 57'h1FBDDA769A46910);
  end

  assign data_o = {c ^ 7'h2A, data_i};
endmodule

module prim_secded_inv_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);
  logic [6:0] c;

  // Parity groups, then inversion of the check field
  always_comb begin
    c[0] = ^(data_i & 32'h2606BD25);
    c[1] = ^(data_i & 32'hDEBA8050);
    c[2] = ^(data_i & 32'h413D89AA);
    c[3] = ^(data_i & 32'h31234ED1);
    c[4] = ^(data_i & 32'hC2C1323B);
    c[5] = ^(data_i & 32'h2DCC624C);
    c[6] = ^(data_i & 32'h98505586);
  end

  assign data_o = {c ^ 7'h2A, data_i};
endmodule
`endif

// File: rtl/tlul_rsp_intg_chk_core.sv
// Combinational integrity check of one incoming d2h beat. Any nonzero
// syndrome (correctable or not) in an enabled check raises err_pulse_raw;
// a disabled check always reports "no error".
module tlul_rsp_intg_chk_core
  import tlul_pkg::*;
#(
  parameter bit EnableRspIntgChk  = 1'b1,
  parameter bit EnableDataIntgChk = 1'b1
) (
  input  logic [D2HRspMaxWidth-1:0]  rsp_payload_i,
  input  logic [D2HRspIntgWidth-1:0] rsp_intg_i,
  input  logic [31:0]                data_i,
  input  logic [DataIntgWidth-1:0]   data_intg_i,
  output logic                       err_pulse_raw
);
  logic [1:0] rsp_err;
  logic [1:0] data_err;

  prim_secded_inv_64_57_dec u_rsp_dec (
    .data_i ({rsp_intg_i, rsp_payload_i}),
    .err_o  (rsp_err)
  );

  prim_secded_inv_39_32_dec u_data_dec (
    .data_i ({data_intg_i, data_i}),
    .err_o  (data_err)
  );

  assign err_pulse_raw = (EnableRspIntgChk  && (|rsp_err)) ||
                         (EnableDataIntgChk && (|data_err));
endmodule

// File: rtl/tlul_rsp_intg_chk_slice.sv
// Host-side TL-UL D-channel slice: a 2-entry full-throughput skid buffer
// with response/data integrity checking, a sticky error flag and an alert
// request/acknowledge handshake.
//
// Handshake: a beat moves upstream when tl_d_i.d_valid & d_ready_o and
// downstream when tl_d_o.d_valid & d_ready_i; d_ready_o depends only on
// registered occupancy, never on d_ready_i. a_ready bypasses the buffer.
//
// Build option TLUL_RSP_CHK_BLOCK_EN: a failing beat, and every beat after
// the sticky error is set, is stored as an error response (d_error=1,
// data=0) with freshly encoded integrity so downstream checks pass.
module tlul_rsp_intg_chk_slice
  import tlul_pkg::*;
#(
  parameter bit EnableRspIntgChk  = 1'b1,
  parameter bit EnableDataIntgChk = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [D2HWidth-1:0] tl_d_i,
  output logic                d_ready_o,
  output logic [D2HWidth-1:0] tl_d_o,
  input  logic                d_ready_i,
  output logic                intg_err_o,
  output logic                alert_req_o,
  input  logic                alert_ack_i
);
  slice_state_e state_q, state_d;
  logic [DOpcodeMsb:DErrorBit] main_q, skid_q, beat_in;
  logic main_load, main_from_skid, skid_load;
  logic accept, drain;
  logic err_pulse_raw, err_pulse;
  logic intg_err_q, alert_req_q;

  assign d_ready_o = (state_q != SliceFull);
  assign accept    = tl_d_i[DValidBit] & d_ready_o;
  assign drain     = (state_q != SliceEmpty) & d_ready_i;
  assign err_pulse = accept & err_pulse_raw;

  tlul_rsp_intg_chk_core #(
    .EnableRspIntgChk  (EnableRspIntgChk),
    .EnableDataIntgChk (EnableDataIntgChk)
  ) u_core (
    .rsp_payload_i (rsp_payload(tl_d_i[DOpcodeMsb:DOpcodeLsb],
                                tl_d_i[DSizeMsb:DSizeLsb], tl_d_i[DErrorBit])),
    .rsp_intg_i    (tl_d_i[DRspIntgMsb:DRspIntgLsb]),
    .data_i        (tl_d_i[DDataMsb:DDataLsb]),
    .data_intg_i   (tl_d_i[DDataIntgMsb:DDataIntgLsb]),
    .err_pulse_raw (err_pulse_raw)
  );

`ifdef TLUL_RSP_CHK_BLOCK_EN
  logic [63:0] blk_rsp_cw;
  logic [38:0] blk_data_cw;

  prim_secded_inv_64_57_enc u_rsp_enc (
    .data_i (rsp_payload(tl_d_i[DOpcodeMsb:DOpcodeLsb],
                         tl_d_i[DSizeMsb:DSizeLsb], 1'b1)),
    .data_o (blk_rsp_cw)
  );

  prim_secded_inv_39_32_enc u_data_enc (
    .data_i (32'h0),
    .data_o (blk_data_cw)
  );

  // Replace a suspect beat with a well-formed error response
  always_comb begin
    beat_in = tl_d_i[DOpcodeMsb:DErrorBit];
    if (err_pulse_raw || intg_err_q) begin
      beat_in[DDataMsb:DDataLsb]         = '0;
      beat_in[DErrorBit]                 = 1'b1;
      beat_in[DRspIntgMsb:DRspIntgLsb]   = blk_rsp_cw[63:57];
      beat_in[DDataIntgMsb:DDataIntgLsb] = blk_data_cw[38:32];
    end
  end
`else
  assign beat_in = tl_d_i[DOpcodeMsb:DErrorBit];
`endif

  // Occupancy next-state and register-load selects
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      SliceEmpty: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = SliceOne;
        end
      end
      SliceOne: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = SliceFull;
        end else if (drain) begin
          state_d = SliceEmpty;
        end
      end
      SliceFull: begin
        if (drain) begin
          main_from_skid = 1'b1;
          state_d        = SliceOne;
        end
      end
      default: state_d = SliceEmpty;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SliceEmpty;
    else       state_q <= state_d;
  end

  // Main and skid beat registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load)           main_q <= beat_in;
      else if (main_from_skid) main_q <= skid_q;
      if (skid_load)           skid_q <= beat_in;
    end
  end

  // Sticky error and alert request; a new error wins over an acknowledge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intg_err_q  <= 1'b0;
      alert_req_q <= 1'b0;
    end else begin
      intg_err_q  <= intg_err_q | err_pulse;
      alert_req_q <= err_pulse | (alert_req_q & ~alert_ack_i);
    end
  end

  assign tl_d_o      = {(state_q != SliceEmpty), main_q, tl_d_i[AReadyBit]};
  assign intg_err_o  = intg_err_q;
  assign alert_req_o = alert_req_q;
endmodule

// File: tb/tb_tlul_rsp_intg_chk_slice.sv
// Bench for tlul_rsp_intg_chk_slice. A default-parameter DUT and a DUT with
// both checks disabled see the same stimulus; a queue-based reference model
// (a 2-deep FIFO with registered ready, an integrity oracle and the
// error/alert rules) is compared against both on every falling edge.
module tb_tlul_rsp_intg_chk_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] tl_d_i;
  logic        d_ready_i;
  logic        alert_ack_i;
  logic        d_ready_o, intg_err_o, alert_req_o;
  logic [65:0] tl_d_o;
  logic        nc_d_ready_o, nc_intg_err_o, nc_alert_req_o;
  logic [65:0] nc_tl_d_o;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  tlul_rsp_intg_chk_slice u_dut (
    .clk_i (clk), .rst_i (rst), .tl_d_i (tl_d_i), .d_ready_o (d_ready_o),
    .tl_d_o (tl_d_o), .d_ready_i (d_ready_i), .intg_err_o (intg_err_o),
    .alert_req_o (alert_req_o), .alert_ack_i (alert_ack_i)
  );

  tlul_rsp_intg_chk_slice #(
    .EnableRspIntgChk (1'b0), .EnableDataIntgChk (1'b0)
  ) u_dut_nc (
    .clk_i (clk), .rst_i (rst), .tl_d_i (tl_d_i), .d_ready_o (nc_d_ready_o),
    .tl_d_o (nc_tl_d_o), .d_ready_i (d_ready_i), .intg_err_o (nc_intg_err_o),
    .alert_req_o (nc_alert_req_o), .alert_ack_i (alert_ack_i)
  );

  // ---------------- integrity reference ----------------
  function automatic logic [56:0] rsp_mask(input int i);
    case (i)
      0: return 57'h103FFF800007FFF;
      1: return 57'h17C1FF801FF801F;
      2: return 57'h1BDE1F87E0781E1;
      3: return 57'h1DEEE3B8E388E22;
      4: return 57'h1EF76CDB2C93244;
      5: return 57'h1F7BB56D5525488;
      default: return 57'h1FBDDA769A46910;
    endcase
  endfunction

  function automatic logic [31:0] data_mask(input int i);
    case (i)
      0: return 32'h2606BD25;
      1: return 32'hDEBA8050;
      2: return 32'h413D89AA;
      3: return 32'h31234ED1;
      4: return 32'hC2C1323B;
      5: return 32'h2DCC624C;
      default: return 32'h98505586;
    endcase
  endfunction

  function automatic logic [6:0] enc_rsp(input logic [56:0] p);
    logic [6:0] c;
    for (int i = 0; i < 7; i++) c[i] = ^(p & rsp_mask(i));
    return c ^ 7'h2A;
  endfunction

  function automatic logic [6:0] enc_data(input logic [31:0] d);
    logic [6:0] c;
    for (int i = 0; i < 7; i++) c[i] = ^(d & data_mask(i));
    return c ^ 7'h2A;
  endfunction

  function automatic logic [56:0] payload_of(input logic [65:0] b);
    return {51'b0, b[64:62], b[58:57], b[1]};
  endfunction

  // A beat fails when its stored check bits differ from a fresh encoding
  function automatic logic check_fails(input logic [65:0] b, input bit rsp_en,
                                       input bit data_en);
    logic rsp_bad, data_bad;
    rsp_bad  = (b[15:9] != enc_rsp(payload_of(b)));
    data_bad = (b[8:2] != enc_data(b[47:16]));
    return (rsp_en && rsp_bad) || (data_en && data_bad);
  endfunction

  function automatic logic [65:0] mk_beat(input logic [2:0] op, input logic [1:0] sz,
                                          input logic [7:0] src, input logic [31:0] data,
                                          input logic err);
    logic [65:0] b;
    b          = '0;
    b[65]      = 1'b1;
    b[64:62]   = op;
    b[58:57]   = sz;
    b[56:49]   = src;
    b[47:16]   = data;
    b[1]       = err;
    b[15:9]    = enc_rsp({51'b0, op, sz, err});
    b[8:2]     = enc_data(data);
    return b;
  endfunction

  function automatic logic [65:0] forced(input logic [65:0] b);
    logic [65:0] f;
    f        = b;
    f[47:16] = 32'h0;
    f[1]     = 1'b1;
    f[15:9]  = enc_rsp({51'b0, b[64:62], b[58:57], 1'b1});
    f[8:2]   = enc_data(32'h0);
    return f;
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  logic [63:0] nc_q[$];
  logic        m_err, m_alert;
  logic        m_acc, m_drn, m_fail;
  logic [65:0] m_stored;

  initial begin
    m_err   = 1'b0;
    m_alert = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        nc_q.delete();
        m_err   = 1'b0;
        m_alert = 1'b0;
      end else begin
        m_acc    = tl_d_i[65] && (exp_q.size() < 2);
        m_drn    = (exp_q.size() > 0) && d_ready_i;
        m_fail   = m_acc && check_fails(tl_d_i, 1'b1, 1'b1);
        m_stored = tl_d_i;
`ifdef TLUL_RSP_CHK_BLOCK_EN
        if (m_fail || m_err) m_stored = forced(tl_d_i);
`endif
        if (m_drn) begin
          void'(exp_q.pop_front());
          void'(nc_q.pop_front());
        end
        if (m_acc) begin
          exp_q.push_back(m_stored[64:1]);
          nc_q.push_back(tl_d_i[64:1]);
        end
        m_alert = m_fail ? 1'b1 : (alert_ack_i ? 1'b0 : m_alert);
        if (m_fail) m_err = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("valid", 66'(tl_d_o[65]), 66'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("beat", 66'(tl_d_o[64:1]), 66'(exp_q[0]));
      chk("a_ready", 66'(tl_d_o[0]), 66'(tl_d_i[0]));
      chk("d_ready", 66'(d_ready_o), 66'(exp_q.size() < 2));
      chk("intg_err", 66'(intg_err_o), 66'(m_err));
      chk("alert_req", 66'(alert_req_o), 66'(m_alert));
      chk("nc_valid", 66'(nc_tl_d_o[65]), 66'(nc_q.size() != 0));
      if (nc_q.size() != 0) chk("nc_beat", 66'(nc_tl_d_o[64:1]), 66'(nc_q[0]));
      chk("nc_d_ready", 66'(nc_d_ready_o), 66'(nc_q.size() < 2));
      chk("nc_intg_err", 66'(nc_intg_err_o), 66'(0));
      chk("nc_alert_req", 66'(nc_alert_req_o), 66'(0));
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle of inputs just after the falling edge; return at the
  // next falling edge, after the rising edge that consumed them.
  task automatic step(input logic [65:0] beat, input logic rdy, input logic ack);
    #1;
    tl_d_i      = beat;
    d_ready_i   = rdy;
    alert_ack_i = ack;
    @(negedge clk);
  endtask

  logic [65:0] b, b1, b2, b3, exp_b;
  int r;

  initial begin
    tl_d_i      = '0;
    d_ready_i   = 1'b0;
    alert_ack_i = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);

    // Pin the integrity model with hand-computed encodings
    chk("enc_data_0", 66'(enc_data(32'h0)), 66'h2A);
    chk("enc_data_1", 66'(enc_data(32'h1)), 66'h33);
    chk("enc_rsp_0", 66'(enc_rsp(57'h0)), 66'h2A);
    chk("enc_rsp_1", 66'(enc_rsp(57'h1)), 66'h2D);

    // Reset values
    chk("rst_tl_d_o", tl_d_o, 66'h0);
    chk("rst_d_ready", 66'(d_ready_o), 66'h1);
    chk("rst_intg_err", 66'(intg_err_o), 66'h0);
    chk("rst_alert", 66'(alert_req_o), 66'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;

    // Clean stream: each beat appears unchanged one cycle later
    for (int k = 1; k <= 8; k++) begin
      b = mk_beat(AccessAckDataC(), 2'd2, 8'(k), 32'(k), 1'b0);
      step(b, 1'b1, 1'b0);
      chk("clean_beat", tl_d_o, b);
      chk("clean_d_ready", 66'(d_ready_o), 66'h1);
      chk("clean_intg_err", 66'(intg_err_o), 66'h0);
    end
    step('0, 1'b1, 1'b0);
    chk("clean_drained", 66'(tl_d_o[65]), 66'h0);

    // Backpressure: two accepts fill the slice, third beat is held
    b1 = mk_beat(3'h0, 2'd2, 8'h1, 32'h11, 1'b0);
    b2 = mk_beat(3'h0, 2'd2, 8'h2, 32'h22, 1'b0);
    b3 = mk_beat(3'h0, 2'd2, 8'h3, 32'h33, 1'b0);
    step(b1, 1'b0, 1'b0);
    chk("bp_ready_after_1", 66'(d_ready_o), 66'h1);
    step(b2, 1'b0, 1'b0);
    chk("bp_ready_after_2", 66'(d_ready_o), 66'h0);
    step(b3, 1'b0, 1'b0);
    chk("bp_hold_head", 66'(tl_d_o[47:16]), 66'h11);
    step(b3, 1'b1, 1'b0);
    chk("bp_drain_2", 66'(tl_d_o[47:16]), 66'h22);
    step(b3, 1'b1, 1'b0);
    chk("bp_drain_3", 66'(tl_d_o[47:16]), 66'h33);
    step('0, 1'b1, 1'b0);
    chk("bp_empty", 66'(tl_d_o[65]), 66'h0);

    // Data bit 0 flipped
    b = mk_beat(3'h1, 2'd2, 8'h5, 32'hDEAD_BEEF, 1'b0);
    b[16] = ~b[16];
    step(b, 1'b1, 1'b0);
    chk("dflip_intg_err", 66'(intg_err_o), 66'h1);
    chk("dflip_alert", 66'(alert_req_o), 66'h1);
`ifdef TLUL_RSP_CHK_BLOCK_EN
    exp_b = forced(b);
`else
    exp_b = b;
`endif
    chk("dflip_beat", tl_d_o, exp_b);
    step('0, 1'b1, 1'b1);
    chk("ack_clears_alert", 66'(alert_req_o), 66'h0);
    chk("ack_keeps_err", 66'(intg_err_o), 66'h1);

    // Response check bit flipped, then acknowledged
    b = mk_beat(3'h0, 2'd1, 8'h6, 32'h0, 1'b0);
    b[9] = ~b[9];
    step(b, 1'b1, 1'b0);
    chk("rflip_alert", 66'(alert_req_o), 66'h1);
    step('0, 1'b1, 1'b1);
    chk("rflip_ack_alert", 66'(alert_req_o), 66'h0);
    chk("rflip_ack_err", 66'(intg_err_o), 66'h1);

    // Acknowledge coinciding with a new error keeps the alert up
    step('0, 1'b1, 1'b0);
    step(b, 1'b1, 1'b0);
    step(b, 1'b1, 1'b1);
    chk("coinc_alert", 66'(alert_req_o), 66'h1);
    step('0, 1'b1, 1'b0);
    chk("coinc_alert_held", 66'(alert_req_o), 66'h1);
    step('0, 1'b1, 1'b1);
    chk("coinc_cleared", 66'(alert_req_o), 66'h0);
    chk("nc_no_err", 66'(nc_intg_err_o), 66'h0);

    // Asynchronous reset with the slice full
    step(b1, 1'b0, 1'b0);
    step(b2, 1'b0, 1'b0);
    chk("full_before_rst", 66'(d_ready_o), 66'h0);
    b = '0;
    b[65] = 1'b1;
    #3;
    cmp_en = 1'b0;
    tl_d_i = b;
    rst    = 1'b1;
    #1;
    chk("arst_tl_d_o", tl_d_o, 66'h0);
    chk("arst_d_ready", 66'(d_ready_o), 66'h1);
    chk("arst_intg_err", 66'(intg_err_o), 66'h0);
    chk("arst_alert", 66'(alert_req_o), 66'h0);
    @(negedge clk);
    #1;
    rst       = 1'b0;
    tl_d_i    = '0;
    d_ready_i = 1'b1;
    @(negedge clk);
    chk("arst_empty", 66'(tl_d_o[65]), 66'h0);
    chk("arst_ready", 66'(d_ready_o), 66'h1);
    cmp_en = 1'b1;

    // Randomised traffic with occasional corruption and acknowledges
    for (int n = 0; n < 600; n++) begin
      b = mk_beat(3'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  32'($urandom), 1'($urandom_range(0, 1)));
      b[65] = ($urandom_range(0, 3) != 0);
      b[0]  = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 11);
      if (r == 0)      b[$urandom_range(2, 47)] = ~b[$urandom_range(2, 47)];
      else if (r == 1) b[1] = ~b[1];
      else if (r == 2) b[62] = ~b[62];
      if (n == 300) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
      end
      step(b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic [2:0] AccessAckDataC();
    return 3'h1;
  endfunction

endmodule
